// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode/operand stage: bus widths, ALU
// operation encodings and the instruction opcode/funct values we decode.
package id_operand_stage_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic [3:0] ALUOP_ADD = 4'd0;
   localparam logic [3:0] ALUOP_SUB = 4'd1;
   localparam logic [3:0] ALUOP_AND = 4'd2;
   localparam logic [3:0] ALUOP_OR  = 4'd3;
   localparam logic [3:0] ALUOP_XOR = 4'd4;
   localparam logic [3:0] ALUOP_NOR = 4'd5;
   localparam logic [3:0] ALUOP_SLT = 4'd6;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Single-source operand forward mux: the EX result wins over the MEM
// result, which wins over the regfile. Register 0 is hardwired, so it is
// never taken from a forward path.
module operand_fwd_mux
   import id_operand_stage_pkg::*;
#(
   parameter int DW = RegBus,
   parameter int AW = RegAddrBus
) (
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] rdata,
   input  logic          ex_wreg,
   input  logic [AW-1:0] ex_wd,
   input  logic [DW-1:0] ex_wdata,
   input  logic          mem_wreg,
   input  logic [AW-1:0] mem_wd,
   input  logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] data
);

   // Priority select of the youngest in-flight producer of addr.
   always_comb begin
      data = rdata;
      if (addr != '0) begin
         if (ex_wreg && (ex_wd == addr)) begin
            data = ex_wdata;
         end else if (mem_wreg && (mem_wd == addr)) begin
            data = mem_wdata;
         end
      end
   end

endmodule

// File: rtl/id_operand_stage.sv
// Decode stage on the regfile read ports: decodes the instruction, reads
// and forwards rs/rt, stalls one cycle on a load-use hazard and registers
// the result into the ID/EX pipeline register.
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int DW = RegBus,
   parameter int AW = RegAddrBus
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [31:0]   id_inst,
   input  logic [31:0]   id_pc,
   output logic          id_ready,
   output logic          re1,
   output logic          re2,
   output logic [AW-1:0] raddr1,
   output logic [AW-1:0] raddr2,
   input  logic [DW-1:0] rdata1,
   input  logic [DW-1:0] rdata2,
   input  logic          ex_fwd_wreg,
   input  logic [AW-1:0] ex_fwd_wd,
   input  logic [DW-1:0] ex_fwd_wdata,
   input  logic          mem_fwd_wreg,
   input  logic [AW-1:0] mem_fwd_wd,
   input  logic [DW-1:0] mem_fwd_wdata,
   input  logic          ex_stall,
   input  logic          flush,
   output logic          ex_valid,
   output logic [3:0]    ex_aluop,
   output logic [DW-1:0] ex_src1,
   output logic [DW-1:0] ex_src2,
   output logic [DW-1:0] ex_store_data,
   output logic [AW-1:0] ex_wd,
   output logic          ex_wreg,
   output logic          ex_is_load,
   output logic          ex_is_store,
   output logic          ex_illegal,
   output logic [31:0]   ex_pc
);

   function automatic logic [DW-1:0] sext_imm(input logic [15:0] imm);
      logic signed [15:0] s;
      s = signed'(imm);
      return DW'(s);
   endfunction

   function automatic logic [DW-1:0] zext_imm(input logic [15:0] imm);
      return DW'(imm);
   endfunction

   logic [5:0]    op;
   logic [5:0]    funct;
   logic [15:0]   imm;
   logic [AW-1:0] rt_a;
   logic [AW-1:0] rd_a;
   logic [DW-1:0] fwd1;
   logic [DW-1:0] fwd2;

   logic [3:0]    d_aluop;
   logic [DW-1:0] d_src1;
   logic [DW-1:0] d_src2;
   logic [DW-1:0] d_store;
   logic [AW-1:0] d_wd;
   logic          d_wreg;
   logic          d_is_load;
   logic          d_is_store;
   logic          d_illegal;
   logic          r_ok;
   logic [3:0]    r_aluop;
   logic          hazard;

   assign op     = id_inst[31:26];
   assign funct  = id_inst[5:0];
   assign imm    = id_inst[15:0];
   assign raddr1 = AW'(id_inst[25:21]);
   assign raddr2 = AW'(id_inst[20:16]);
   assign rt_a   = AW'(id_inst[20:16]);
   assign rd_a   = AW'(id_inst[15:11]);

   operand_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
      .addr     (raddr1),
      .rdata    (rdata1),
      .ex_wreg  (ex_fwd_wreg),
      .ex_wd    (ex_fwd_wd),
      .ex_wdata (ex_fwd_wdata),
      .mem_wreg (mem_fwd_wreg),
      .mem_wd   (mem_fwd_wd),
      .mem_wdata(mem_fwd_wdata),
      .data     (fwd1)
   );

   operand_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
      .addr     (raddr2),
      .rdata    (rdata2),
      .ex_wreg  (ex_fwd_wreg),
      .ex_wd    (ex_fwd_wd),
      .ex_wdata (ex_fwd_wdata),
      .mem_wreg (mem_fwd_wreg),
      .mem_wd   (mem_fwd_wd),
      .mem_wdata(mem_fwd_wdata),
      .data     (fwd2)
   );

   // R-type funct field to ALU operation; r_ok flags a recognised funct.
   always_comb begin
      r_ok    = 1'b1;
      r_aluop = ALUOP_ADD;
      case (funct)
         FUNCT_ADD, FUNCT_ADDU: r_aluop = ALUOP_ADD;
         FUNCT_SUB, FUNCT_SUBU: r_aluop = ALUOP_SUB;
         FUNCT_AND:             r_aluop = ALUOP_AND;
         FUNCT_OR:              r_aluop = ALUOP_OR;
         FUNCT_XOR:             r_aluop = ALUOP_XOR;
         FUNCT_NOR:             r_aluop = ALUOP_NOR;
         FUNCT_SLT:             r_aluop = ALUOP_SLT;
         default:               r_ok    = 1'b0;
      endcase
   end

   // Instruction decode and operand selection; everything idles without id_valid.
   always_comb begin
      d_aluop    = ALUOP_ADD;
      d_src1     = '0;
      d_src2     = '0;
      d_store    = '0;
      d_wd       = '0;
      d_wreg     = 1'b0;
      d_is_load  = 1'b0;
      d_is_store = 1'b0;
      d_illegal  = 1'b0;
      re1        = 1'b0;
      re2        = 1'b0;
      if (id_valid && (id_inst != 32'h0)) begin
         case (op)
            OP_SPECIAL: begin
               if (r_ok) begin
                  d_aluop = r_aluop;
                  d_src1  = fwd1;
                  d_src2  = fwd2;
                  d_wd    = rd_a;
                  d_wreg  = 1'b1;
                  re1     = 1'b1;
                  re2     = 1'b1;
               end else begin
                  d_illegal = 1'b1;
               end
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
               d_src1 = fwd1;
               d_wd   = rt_a;
               d_wreg = 1'b1;
               re1    = 1'b1;
               case (op)
                  OP_ANDI: begin d_aluop = ALUOP_AND; d_src2 = zext_imm(imm); end
                  OP_ORI:  begin d_aluop = ALUOP_OR;  d_src2 = zext_imm(imm); end
                  OP_XORI: begin d_aluop = ALUOP_XOR; d_src2 = zext_imm(imm); end
                  default: begin d_aluop = ALUOP_ADD; d_src2 = sext_imm(imm); end
               endcase
            end
            OP_LUI: begin
               d_aluop = ALUOP_OR;
               d_src2  = DW'({imm, 16'h0000});
               d_wd    = rt_a;
               d_wreg  = 1'b1;
            end
            OP_LW: begin
               d_src1    = fwd1;
               d_src2    = sext_imm(imm);
               d_wd      = rt_a;
               d_wreg    = 1'b1;
               d_is_load = 1'b1;
               re1       = 1'b1;
            end
            OP_SW: begin
               d_src1     = fwd1;
               d_src2     = sext_imm(imm);
               d_store    = fwd2;
               d_is_store = 1'b1;
               re1        = 1'b1;
               re2        = 1'b1;
            end
            default: d_illegal = 1'b1;
         endcase
         if (d_wd == '0) d_wreg = 1'b0;
      end
   end

   assign hazard = ex_valid && ex_is_load && ex_wreg &&
                   ((re1 && (raddr1 == ex_wd)) || (re2 && (raddr2 == ex_wd)));

   // Consume the instruction unless held downstream or waiting one cycle on a load.
   assign id_ready = !rst && (flush || (!ex_stall && !hazard));

   // ID/EX pipeline register: rst > flush > ex_stall > hazard > id_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_aluop      <= '0;
         ex_src1       <= '0;
         ex_src2       <= '0;
         ex_store_data <= '0;
         ex_wd         <= '0;
         ex_wreg       <= 1'b0;
         ex_is_load    <= 1'b0;
         ex_is_store   <= 1'b0;
         ex_illegal    <= 1'b0;
         ex_pc         <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (!ex_stall) begin
         if (hazard || !id_valid) begin
            ex_valid <= 1'b0;
         end else begin
            ex_valid      <= 1'b1;
            ex_aluop      <= d_aluop;
            ex_src1       <= d_src1;
            ex_src2       <= d_src2;
            ex_store_data <= d_store;
            ex_wd         <= d_wd;
            ex_wreg       <= d_wreg;
            ex_is_load    <= d_is_load;
            ex_is_store   <= d_is_store;
            ex_illegal    <= d_illegal;
            ex_pc         <= id_pc;
         end
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage with an instruction-level
// reference model of decode, forwarding, load-use stalls and the ID/EX register.
module tb_id_operand_stage;

   typedef struct packed {
      logic        valid;
      logic [3:0]  aluop;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] store;
      logic [4:0]  wd;
      logic        wreg;
      logic        is_load;
      logic        is_store;
      logic        illegal;
      logic [31:0] pc;
   } ex_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_ready;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2;
   logic [31:0] rdata1, rdata2;
   logic        ex_fwd_wreg, mem_fwd_wreg;
   logic [4:0]  ex_fwd_wd, mem_fwd_wd;
   logic [31:0] ex_fwd_wdata, mem_fwd_wdata;
   logic        ex_stall, flush;
   logic        ex_valid;
   logic [3:0]  ex_aluop;
   logic [31:0] ex_src1, ex_src2, ex_store_data, ex_pc;
   logic [4:0]  ex_wd;
   logic        ex_wreg, ex_is_load, ex_is_store, ex_illegal;

   logic [31:0] rf [0:31];
   ex_t         dut_ex;
   ex_t         exp;
   ex_t         exp_next;
   logic        exp_ready;
   logic        rdy_seen;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   assign rdata1 = rf[raddr1];
   assign rdata2 = rf[raddr2];
   assign dut_ex = {ex_valid, ex_aluop, ex_src1, ex_src2, ex_store_data, ex_wd,
                    ex_wreg, ex_is_load, ex_is_store, ex_illegal, ex_pc};

   id_operand_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_ready(id_ready), .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .ex_fwd_wreg(ex_fwd_wreg), .ex_fwd_wd(ex_fwd_wd), .ex_fwd_wdata(ex_fwd_wdata),
      .mem_fwd_wreg(mem_fwd_wreg), .mem_fwd_wd(mem_fwd_wd), .mem_fwd_wdata(mem_fwd_wdata),
      .ex_stall(ex_stall), .flush(flush),
      .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_src1(ex_src1), .ex_src2(ex_src2),
      .ex_store_data(ex_store_data), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_illegal(ex_illegal),
      .ex_pc(ex_pc)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] opnd(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (ex_fwd_wreg && ex_fwd_wd == a) return ex_fwd_wdata;
      if (mem_fwd_wreg && mem_fwd_wd == a) return mem_fwd_wdata;
      return rf[a];
   endfunction

   function automatic logic r_funct_known(input logic [5:0] fn);
      return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
   endfunction

   // {reads rs, reads rt} of a (non-NOP) instruction
   function automatic logic [1:0] reads(input logic [31:0] inst);
      logic [5:0] op;
      op = inst[31:26];
      if (inst == 32'h0) return 2'b00;
      if (op == 6'h00) return r_funct_known(inst[5:0]) ? 2'b11 : 2'b00;
      if (op inside {6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23}) return 2'b10;
      if (op == 6'h2B) return 2'b11;
      return 2'b00;
   endfunction

   function automatic ex_t mdl_dec(input logic [31:0] inst, input logic [31:0] pc);
      ex_t r;
      logic [15:0] imm;
      logic [31:0] sx, zx;
      imm = inst[15:0];
      sx = 32'($signed(imm));
      zx = {16'h0, imm};
      r = '0;
      r.valid = 1'b1;
      r.pc = pc;
      if (inst == 32'h0) return r;
      case (inst[31:26])
         6'h00: begin
            if (r_funct_known(inst[5:0])) begin
               r.src1 = opnd(inst[25:21]);
               r.src2 = opnd(inst[20:16]);
               r.wd = inst[15:11];
               r.wreg = 1'b1;
               case (inst[5:0])
                  6'h20, 6'h21: r.aluop = 4'd0;
                  6'h22, 6'h23: r.aluop = 4'd1;
                  6'h24:        r.aluop = 4'd2;
                  6'h25:        r.aluop = 4'd3;
                  6'h26:        r.aluop = 4'd4;
                  6'h27:        r.aluop = 4'd5;
                  default:      r.aluop = 4'd6;
               endcase
            end else r.illegal = 1'b1;
         end
         6'h09: begin r.aluop = 4'd0; r.src1 = opnd(inst[25:21]); r.src2 = sx; r.wd = inst[20:16]; r.wreg = 1'b1; end
         6'h0C: begin r.aluop = 4'd2; r.src1 = opnd(inst[25:21]); r.src2 = zx; r.wd = inst[20:16]; r.wreg = 1'b1; end
         6'h0D: begin r.aluop = 4'd3; r.src1 = opnd(inst[25:21]); r.src2 = zx; r.wd = inst[20:16]; r.wreg = 1'b1; end
         6'h0E: begin r.aluop = 4'd4; r.src1 = opnd(inst[25:21]); r.src2 = zx; r.wd = inst[20:16]; r.wreg = 1'b1; end
         6'h0F: begin r.aluop = 4'd3; r.src1 = 32'h0; r.src2 = {imm, 16'h0}; r.wd = inst[20:16]; r.wreg = 1'b1; end
         6'h23: begin r.aluop = 4'd0; r.src1 = opnd(inst[25:21]); r.src2 = sx; r.wd = inst[20:16]; r.wreg = 1'b1; r.is_load = 1'b1; end
         6'h2B: begin r.aluop = 4'd0; r.src1 = opnd(inst[25:21]); r.src2 = sx; r.store = opnd(inst[20:16]); r.is_store = 1'b1; end
         default: r.illegal = 1'b1;
      endcase
      if (r.wd == 5'd0) r.wreg = 1'b0;
      return r;
   endfunction

   // Fields with no architectural meaning for a given entry are not compared.
   function automatic ex_t mk_mask(input ex_t e);
      ex_t m;
      m = '1;
      if (!e.valid) begin
         m = '0;
         m.valid = 1'b1;
      end else begin
         if (!e.wreg && !e.is_store) begin m.aluop = '0; m.src1 = '0; m.src2 = '0; end
         if (!e.wreg) m.wd = '0;
         if (!e.is_store) m.store = '0;
      end
      return m;
   endfunction

   task automatic mdl_step();
      logic [1:0] rd;
      logic hz;
      rd = reads(id_inst);
      hz = id_valid && exp.valid && exp.is_load && exp.wreg &&
           ((rd[1] && id_inst[25:21] == exp.wd) || (rd[0] && id_inst[20:16] == exp.wd));
      exp_ready = !rst && (flush || (!ex_stall && !hz));
      exp_next = exp;
      if (rst) exp_next = '0;
      else if (flush) exp_next.valid = 1'b0;
      else if (ex_stall) exp_next = exp;
      else if (hz || !id_valid) exp_next.valid = 1'b0;
      else exp_next = mdl_dec(id_inst, id_pc);
   endtask

   // One clock: model evaluated on the falling edge, outputs settled 1 after the rising edge.
   task automatic cyc();
      @(negedge clk);
      mdl_step();
      rdy_seen = id_ready;
      @(posedge clk);
      exp = exp_next;
      #1;
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [4:0] rs, rt, rd;
      logic [15:0] imm;
      logic [5:0] fn;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 8))
         0: fn = 6'h20; 1: fn = 6'h21; 2: fn = 6'h22; 3: fn = 6'h23; 4: fn = 6'h24;
         5: fn = 6'h25; 6: fn = 6'h26; 7: fn = 6'h27; default: fn = 6'h2A;
      endcase
      case ($urandom_range(0, 11))
         0, 1:    return {6'h00, rs, rt, rd, 5'd0, fn};
         2:       return {6'h09, rs, rt, imm};
         3:       return {6'h0C, rs, rt, imm};
         4:       return {6'h0D, rs, rt, imm};
         5:       return {6'h0E, rs, rt, imm};
         6:       return {6'h0F, rs, rt, imm};
         7, 8:    return {6'h23, rs, rt, imm};
         9:       return {6'h2B, rs, rt, imm};
         10:      return $urandom;
         default: return 32'h0;
      endcase
   endfunction

   task automatic idle_inputs();
      id_valid = 1'b0; id_inst = 32'h0; id_pc = 32'h0;
      ex_fwd_wreg = 1'b0; ex_fwd_wd = 5'd0; ex_fwd_wdata = 32'h0;
      mem_fwd_wreg = 1'b0; mem_fwd_wd = 5'd0; mem_fwd_wdata = 32'h0;
      ex_stall = 1'b0; flush = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      id_valid = 1'b1; id_inst = {6'h09, 5'd0, 5'd1, 16'd5}; id_pc = 32'h100;
      cyc();
      total++;
      if (dut_ex !== ex_t'(0)) begin bad++; $display("FAIL reset_ex: got=%h want=0", dut_ex); end
      total++;
      if (rdy_seen !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b want=0", rdy_seen); end
      rst = 1'b0;
      idle_inputs();
      cyc();
   endtask

   task automatic test_addiu();
      id_valid = 1'b1; id_inst = {6'h09, 5'd0, 5'd1, 16'd5}; id_pc = 32'h200;
      #1;
      total++;
      if (re1 !== 1'b1 || raddr1 !== 5'd0) begin bad++; $display("FAIL addiu_read: got re1=%b raddr1=%0d want 1/0", re1, raddr1); end
      cyc();
      total++;
      if (ex_src1 !== 32'd0 || ex_src2 !== 32'd5 || ex_wd !== 5'd1 || ex_wreg !== 1'b1 || ex_aluop !== 4'd0 || ex_valid !== 1'b1)
         begin bad++; $display("FAIL addiu_ex: got=%h want src1=0 src2=5 wd=1 wreg=1 add", dut_ex); end
      total++;
      if ((dut_ex & mk_mask(exp)) !== (exp & mk_mask(exp))) begin bad++; $display("FAIL addiu_model: got=%h want=%h", dut_ex, exp); end
   endtask

   task automatic test_forward();
      rf[1] = 32'd7; rf[2] = 32'd9;
      id_valid = 1'b1; id_inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}; id_pc = 32'h300;
      ex_fwd_wreg = 1'b1; ex_fwd_wd = 5'd1; ex_fwd_wdata = 32'hAA;
      mem_fwd_wreg = 1'b1; mem_fwd_wd = 5'd1; mem_fwd_wdata = 32'hBB;
      cyc();
      total++;
      if (ex_src1 !== 32'hAA || ex_src2 !== 32'd9) begin bad++; $display("FAIL fwd_ex_prio: got src1=%h src2=%h want aa/9", ex_src1, ex_src2); end
      ex_fwd_wreg = 1'b0;
      cyc();
      total++;
      if (ex_src1 !== 32'hBB || ex_src2 !== 32'd9) begin bad++; $display("FAIL fwd_mem: got src1=%h src2=%h want bb/9", ex_src1, ex_src2); end
      id_inst = {6'h00, 5'd0, 5'd2, 5'd4, 5'd0, 6'h22};
      ex_fwd_wreg = 1'b1; ex_fwd_wd = 5'd0; ex_fwd_wdata = 32'hDEAD;
      cyc();
      total++;
      if ((dut_ex & mk_mask(exp)) !== (exp & mk_mask(exp)) || ex_src1 !== 32'h0)
         begin bad++; $display("FAIL fwd_zero_reg: got=%h want=%h", dut_ex, exp); end
      idle_inputs();
   endtask

   task automatic test_immediates();
      id_valid = 1'b1; id_inst = {6'h0F, 5'd3, 5'd2, 16'h1234}; id_pc = 32'h400;
      #1;
      total++;
      if (re1 !== 1'b0) begin bad++; $display("FAIL lui_re1: got=%b want=0", re1); end
      cyc();
      total++;
      if (ex_src2 !== 32'h12340000 || ex_src1 !== 32'h0 || ex_aluop !== 4'd3) begin bad++; $display("FAIL lui_ex: got=%h want src2=12340000", dut_ex); end
      id_inst = {6'h0C, 5'd1, 5'd3, 16'hFFFF};
      cyc();
      total++;
      if (ex_src2 !== 32'h0000FFFF) begin bad++; $display("FAIL andi_zext: got=%h want=0000ffff", ex_src2); end
      id_inst = {6'h09, 5'd1, 5'd3, 16'hFFFF};
      cyc();
      total++;
      if (ex_src2 !== 32'hFFFFFFFF) begin bad++; $display("FAIL addiu_sext: got=%h want=ffffffff", ex_src2); end
      idle_inputs();
   endtask

   task automatic test_load_use();
      logic [31:0] md;
      md = $urandom;
      id_valid = 1'b1; id_inst = {6'h23, 5'd1, 5'd4, 16'd8}; id_pc = 32'h500;
      cyc();
      total++;
      if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_wd !== 5'd4) begin bad++; $display("FAIL lw_issue: got=%h want load wd=4", dut_ex); end
      id_inst = {6'h00, 5'd4, 5'd4, 5'd5, 5'd0, 6'h20}; id_pc = 32'h504;
      cyc();
      total++;
      if (rdy_seen !== 1'b0 || ex_valid !== 1'b0) begin bad++; $display("FAIL loaduse_bubble: got ready=%b ex_valid=%b want 0/0", rdy_seen, ex_valid); end
      mem_fwd_wreg = 1'b1; mem_fwd_wd = 5'd4; mem_fwd_wdata = md;
      cyc();
      total++;
      if (rdy_seen !== 1'b1 || ex_valid !== 1'b1 || ex_src1 !== md || ex_src2 !== md || ex_pc !== 32'h504)
         begin bad++; $display("FAIL loaduse_issue: got ready=%b ex=%h want src=%h", rdy_seen, dut_ex, md); end
      idle_inputs();
   endtask

   task automatic test_stall();
      id_valid = 1'b1; id_inst = {6'h09, 5'd1, 5'd6, 16'($urandom)}; id_pc = 32'h600;
      cyc();
      id_inst = {6'h0D, 5'd2, 5'd7, 16'($urandom)}; id_pc = 32'h604;
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         total++;
         if (rdy_seen !== 1'b0 || (dut_ex & mk_mask(exp)) !== (exp & mk_mask(exp)) || ex_wd !== 5'd6)
            begin bad++; $display("FAIL stall_hold%0d: got ready=%b ex=%h want=%h", i, rdy_seen, dut_ex, exp); end
      end
      ex_stall = 1'b0;
      cyc();
      total++;
      if (rdy_seen !== 1'b1 || ex_wd !== 5'd7 || ex_pc !== 32'h604 || (dut_ex & mk_mask(exp)) !== (exp & mk_mask(exp)))
         begin bad++; $display("FAIL stall_release: got ready=%b ex=%h want=%h", rdy_seen, dut_ex, exp); end
      idle_inputs();
   endtask

   task automatic test_corners();
      id_valid = 1'b1; id_inst = {6'h09, 5'd1, 5'd2, 16'd3}; id_pc = 32'h700;
      flush = 1'b1;
      cyc();
      total++;
      if (rdy_seen !== 1'b1 || ex_valid !== 1'b0) begin bad++; $display("FAIL flush: got ready=%b ex_valid=%b want 1/0", rdy_seen, ex_valid); end
      flush = 1'b0;
      id_inst = {6'h3F, 26'($urandom)}; id_pc = 32'h704;
      cyc();
      total++;
      if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_wreg !== 1'b0) begin bad++; $display("FAIL illegal: got=%h want valid illegal no-wreg", dut_ex); end
      id_inst = {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}; id_pc = 32'h708;
      cyc();
      total++;
      if (ex_valid !== 1'b1 || ex_wreg !== 1'b0 || ex_illegal !== 1'b0) begin bad++; $display("FAIL add_r0: got=%h want wreg=0", dut_ex); end
      id_inst = 32'h0;
      cyc();
      total++;
      if (ex_valid !== 1'b1 || ex_wreg !== 1'b0 || ex_illegal !== 1'b0) begin bad++; $display("FAIL nop: got=%h want legal no-wreg", dut_ex); end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         for (int r = 1; r < 32; r++) rf[r] = $urandom;
         id_valid = ($urandom_range(0, 7) != 0);
         id_inst = rnd_inst();
         id_pc = $urandom;
         ex_fwd_wreg = $urandom_range(0, 1); ex_fwd_wd = 5'($urandom_range(0, 7)); ex_fwd_wdata = $urandom;
         mem_fwd_wreg = $urandom_range(0, 1); mem_fwd_wd = 5'($urandom_range(0, 7)); mem_fwd_wdata = $urandom;
         ex_stall = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 15) == 0);
         cyc();
         total++;
         if ((dut_ex & mk_mask(exp)) !== (exp & mk_mask(exp))) begin bad++; $display("FAIL rand_ex%0d: got=%h want=%h", n, dut_ex, exp); end
         if (id_valid) begin
            total++;
            if (rdy_seen !== exp_ready) begin bad++; $display("FAIL rand_ready%0d: got=%b want=%b", n, rdy_seen, exp_ready); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_rst_mid();
      id_valid = 1'b1; id_inst = {6'h2B, 5'd1, 5'd2, 16'h0010}; id_pc = 32'h800;
      cyc();
      rst = 1'b1;
      id_inst = {6'h09, 5'd1, 5'd3, 16'h0001};
      cyc();
      total++;
      if (dut_ex !== exp || dut_ex !== ex_t'(0)) begin bad++; $display("FAIL rst_mid: got=%h want=0", dut_ex); end
      total++;
      if (rdy_seen !== 1'b0) begin bad++; $display("FAIL rst_mid_ready: got=%b want=0", rdy_seen); end
      rst = 1'b0;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) rf[r] = 32'h0;
      exp = '0;
      exp_next = '0;
      exp_ready = 1'b0;
      rdy_seen = 1'b0;
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_addiu();
      test_forward();
      test_immediates();
      test_load_use();
      test_stall();
      test_corners();
      test_random();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode stage sitting directly on the regfile read ports.
- Decodes the instruction, drives raddr1/raddr2/re1/re2 and selects operands, with priority EX forward > MEM forward > regfile data.
- Detects load-use hazards and inserts exactly one bubble per hazard.
- Registers the result into the ID/EX pipeline register, with valid/ready toward the fetch stage and stall/flush from downstream.

Parameters:
- DW, 32, data/operand width (matches RegBus).
- AW, 5, register address width (matches RegAddrBus).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- id_valid  in  1  instruction valid from IF/ID.
- id_inst  in  32  instruction word.
- id_pc  in  32  PC of id_inst.
- id_ready  out  1  instruction consumed this cycle.
- re1/re2  out  1  regfile read enables.
- raddr1/raddr2  out  AW  regfile read addresses (rs/rt).
- rdata1/rdata2  in  DW  regfile read data; WB-to-ID bypass is already done inside the regfile.
- ex_fwd_wreg, ex_fwd_wd, ex_fwd_wdata  in  1/AW/DW  EX-stage result being written.
- mem_fwd_wreg, mem_fwd_wd, mem_fwd_wdata  in  1/AW/DW  MEM-stage final result, including load data.
- ex_stall  in  1  downstream hold.
- flush  in  1  discard the ID instruction and bubble EX.
- ex_valid, ex_aluop(4), ex_src1(DW), ex_src2(DW), ex_store_data(DW), ex_wd(AW), ex_wreg, ex_is_load, ex_is_store, ex_illegal, ex_pc(32)  out  ID/EX register.

Behaviour:
- Reset: all ex_* outputs 0 (ex_valid=0); id_ready=0 while rst.
- Decode (combinational, gated by id_valid):
  - R-type (op 000000), funct add/addu→ADD, sub/subu→SUB, and, or, xor, nor, slt. re1=re2=1, wd=rd, wreg=1.
  - inst==32'h0 is a NOP: wreg=0, illegal=0, re1=re2=0.
  - andi/ori/xori: src2 = zero-extended imm. addiu: src2 = sign-extended imm. For all four: re1=1, wd=rt, wreg=1.
  - lui: aluop=OR, src1=0, src2={imm,16'h0}, re1=0.
  - lw (100011): ADD, src1=rs, src2 = sign-extended imm, wd=rt, is_load=1.
  - sw (101011): ADD, store_data = fwd(rt), re2=1, wreg=0, is_store=1.
  - Any other encoding: illegal=1, wreg=0, re1=re2=0.
  - Any instruction writing wd=0 forces wreg=0.
- Forwarding per source, for address a ≠ 0:
  - EX match (ex_fwd_wreg && ex_fwd_wd==a) takes priority.
  - Otherwise MEM match.
  - Otherwise rdata.
  - Address 0 is never forwarded.
- Load-use hazard:
  - Condition: ex_valid && ex_is_load && ex_wreg && (re1&&raddr1==ex_wd || re2&&raddr2==ex_wd).
  - Effect: id_ready=0 and a bubble (ex_valid=0) is loaded next cycle.
  - The following cycle the load sits in MEM; the hazard is gone and MEM forwarding supplies the data. One bubble per hazard.
- Register update priority: rst > flush > ex_stall > hazard > id_valid.
  - flush: ex_valid←0; id_ready=1 (ID instruction dropped).
  - ex_stall: all ex_* hold; id_ready=0.
  - hazard: ex_valid←0; id_ready=0.
  - id_valid: load decoded fields; ex_valid←1; id_ready=1.
  - No id_valid: ex_valid←0.
- Latency: 1 cycle from id_ready to ex_valid.
- Illegal instructions propagate with ex_illegal=1, ex_valid=1.

Decomposition:
- Shared defines package: ALUOP_* encodings (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6), opcode/funct constants, RegBus/RegAddrBus widths.
- One natural sub-module, operand_fwd_mux: a single-source priority forward mux, instantiated twice (rs, rt).
- Decode and the ID/EX register stay in the top module.

Test Plan:
- addiu $1,$0,5 with no forwards:
  - re1=1, raddr1=0; next cycle ex_src1=0, ex_src2=5, ex_wd=1, ex_wreg=1, ex_aluop=ADD.
- add $3,$1,$2, rdata1=7, rdata2=9:
  - with ex_fwd (wd=1, data=0xAA) and mem_fwd (wd=1, data=0xBB): ex_src1=0xAA, ex_src2=9.
  - with only the MEM forward: ex_src1=0xBB.
- lw $4,8($1) followed by add $5,$4,$4:
  - cycle after the lw issues: id_ready=0, next ex_valid=0.
  - one cycle later the add issues with ex_src1=ex_src2=mem_fwd_wdata.
- lui $2,0x1234 → ex_src2=0x12340000, re1=0. andi with imm=0xFFFF → zero-extended src2=0x0000FFFF. addiu with 0xFFFF → src2=0xFFFFFFFF.
- ex_stall=1 for 3 cycles with id_valid=1: all ex_* stable and id_ready=0 throughout; on release, the held instruction issues.
- Corner cases:
  - flush with id_valid=1: next ex_valid=0, id_ready=1.
  - rst mid-stream: next cycle all ex_*=0.
  - opcode 0x3F: ex_illegal=1, ex_wreg=0.
  - add $0,$1,$2: ex_wreg=0.
